// File: rtl/t06_wall_place_sequencer_if.sv
// Wall placement request/status bundle.
// Groups the RNG, snake, border and bitmap signals around the sequencer.
interface t06_wall_place_sequencer_if #(
   parameter int MAX_LENGTH = 30
);
   logic                    place_req;
   logic                    clear_req;
   logic [7:0]              rand_num;
   logic                    rand_en;
   logic [3:0]              snake_head_x;
   logic [3:0]              snake_head_y;
   logic [4:0]              snake_len;
   logic [4*MAX_LENGTH-1:0] snakeArrayX;
   logic [4*MAX_LENGTH-1:0] snakeArrayY;
   logic [3:0]              xmax;
   logic [3:0]              xmin;
   logic [3:0]              ymax;
   logic [3:0]              ymin;
   logic [199:0]            wall_locations;
   logic [5:0]              wall_count;
   logic                    busy;
   logic                    done;
   logic                    fail;

   modport master (
      output place_req, clear_req, rand_num,
      output snake_head_x, snake_head_y, snake_len,
      output snakeArrayX, snakeArrayY,
      output xmax, xmin, ymax, ymin,
      input  rand_en, wall_locations, wall_count,
      input  busy, done, fail
   );

   modport slave (
      input  place_req, clear_req, rand_num,
      input  snake_head_x, snake_head_y, snake_len,
      input  snakeArrayX, snakeArrayY,
      input  xmax, xmin, ymax, ymin,
      output rand_en, wall_locations, wall_count,
      output busy, done, fail
   );
endinterface

// File: rtl/t06_wall_place_sequencer.sv
// Wall-mode tile placement sequencer: draws RNG candidates, checks
// border, walls, head and body, then commits into the wall bitmap.
module t06_wall_place_sequencer #(
   parameter int MAX_LENGTH = 30,
   parameter int MAX_TRIES  = 8,
   parameter int MAX_WALLS  = 40
) (
   input  logic                             system_clk,
   input  logic                             reset,
   t06_wall_place_sequencer_if.slave        bus
);
   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_SAMPLE,
      S_CHECK,
      S_SCAN,
      S_RETRY,
      S_COMMIT,
      S_FAIL,
      S_CLEAR
   } state_e;

   state_e       state_q, state_d;
   logic [7:0]   cand_q, cand_d;
   logic [3:0]   tries_q, tries_d;
   logic [4:0]   idx_q, idx_d;
   logic [199:0] map_q, map_d;
   logic [5:0]   cnt_q, cnt_d;
   logic         full_q, full_d;

   logic [3:0] cx, cy;
   logic [6:0] seg_base;
   logic [3:0] seg_x, seg_y;
   logic       in_x, in_y;
   logic       cand_ok;
   logic       seg_hit;
   logic       last_seg;

   assign cx       = cand_q[3:0];
   assign cy       = cand_q[7:4];
   assign seg_base = {idx_q, 2'b00};
   assign seg_x    = bus.snakeArrayX[seg_base +: 4];
   assign seg_y    = bus.snakeArrayY[seg_base +: 4];
   assign in_x     = (cx > bus.xmin) && (cx < bus.xmax);
   assign in_y     = (cy > bus.ymin) && (cy < bus.ymax);
   assign seg_hit  = (seg_x == cx) && (seg_y == cy);
   assign last_seg = (idx_q == bus.snake_len - 5'd1);

   // Border, bitmap and head are all judged in the single CHECK cycle
   assign cand_ok = (cand_q < 8'd200) && in_x && in_y
                  && !map_q[cand_q]
                  && (cand_q != {bus.snake_head_y, bus.snake_head_x});

   always_ff @(posedge system_clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cand_q  <= '0;
         tries_q <= '0;
         idx_q   <= '0;
         map_q   <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         tries_q <= tries_d;
         idx_q   <= idx_d;
         map_q   <= map_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      tries_d = tries_q;
      idx_d   = idx_q;
      map_d   = map_q;
      cnt_d   = cnt_q;
      full_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.clear_req) begin
               state_d = S_CLEAR;
            end else if (bus.place_req) begin
               if (cnt_q == 6'(MAX_WALLS)) begin
                  full_d = 1'b1;
               end else begin
                  tries_d = '0;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH:  state_d = S_SAMPLE;
         S_SAMPLE: begin
            cand_d  = bus.rand_num;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!cand_ok) begin
               state_d = S_RETRY;
            end else if (bus.snake_len == 5'd0) begin
               state_d = S_COMMIT;
            end else begin
               idx_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (seg_hit) begin
               state_d = S_RETRY;
            end else if (last_seg) begin
               state_d = S_COMMIT;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         S_RETRY: begin
            tries_d = tries_q + 4'd1;
            if (tries_d == 4'(MAX_TRIES)) begin
               state_d = S_FAIL;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_COMMIT: begin
            map_d[cand_q] = 1'b1;
            cnt_d         = cnt_q + 6'd1;
            state_d       = S_IDLE;
         end
         S_FAIL:  state_d = S_IDLE;
         S_CLEAR: begin
            map_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rand_en        = (state_q == S_FETCH);
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.done           = (state_q == S_COMMIT)
                             || (state_q == S_CLEAR);
   assign bus.fail           = (state_q == S_FAIL) || full_q;
   assign bus.wall_locations = map_q;
   assign bus.wall_count     = cnt_q;
endmodule

// File: tb/tb_t06_wall_place_sequencer.sv
// Bench for the wall placement sequencer: directed cases plus
// randomized requests scored against a transaction-level model.
module tb_t06_wall_place_sequencer;
   localparam int ML = 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   t06_wall_place_sequencer_if #(.MAX_LENGTH(ML)) ifc();

   t06_wall_place_sequencer #(
      .MAX_LENGTH(ML),
      .MAX_TRIES(8),
      .MAX_WALLS(40)
   ) dut (
      .system_clk(clk),
      .reset(rst),
      .bus(ifc)
   );

   int checks = 0;
   int failures = 0;

   logic [199:0] m_map;
   int           m_cnt;
   logic [7:0]   cands [8];
   int sx [ML];
   int sy [ML];
   int hx, hy, len, xmn, xmx, ymn, ymx;
   int last_lat, last_en, last_res;
   bit inject;

   task automatic chk(string nm, logic [199:0] got,
                      logic [199:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic drive_cfg();
      ifc.snake_head_x = 4'(hx);
      ifc.snake_head_y = 4'(hy);
      ifc.snake_len    = 5'(len);
      ifc.xmin = 4'(xmn);
      ifc.xmax = 4'(xmx);
      ifc.ymin = 4'(ymn);
      ifc.ymax = 4'(ymx);
      for (int i = 0; i < ML; i++) begin
         ifc.snakeArrayX[4*i +: 4] = 4'(sx[i]);
         ifc.snakeArrayY[4*i +: 4] = 4'(sy[i]);
      end
   endtask

   function automatic bit m_legal(logic [7:0] c);
      int x;
      int y;
      x = int'(c) % 16;
      y = int'(c) / 16;
      if (c >= 8'd200) return 1'b0;
      if (!(x > xmn && x < xmx)) return 1'b0;
      if (!(y > ymn && y < ymx)) return 1'b0;
      if (m_map[c]) return 1'b0;
      if (x == hx && y == hy) return 1'b0;
      for (int i = 0; i < len; i++)
         if (sx[i] == x && sy[i] == y) return 1'b0;
      return 1'b1;
   endfunction

   // mode: 0 place, 1 clear, 2 place and clear together
   task automatic issue(int mode, output int n_en,
                        output int lat, output int res);
      int  k;
      bit  feed;
      k = 0;
      feed = 1'b0;
      n_en = 0;
      lat = 0;
      res = 0;
      @(negedge clk);
      for (int w = 0; w < 600 && ifc.busy; w++) @(negedge clk);
      ifc.place_req = (mode != 1);
      ifc.clear_req = (mode != 0);
      @(posedge clk); #1;
      ifc.place_req = 1'b0;
      ifc.clear_req = 1'b0;
      for (int n = 1; n <= 600; n++) begin
         if (feed) begin
            ifc.rand_num = (k < 8) ? cands[k] : 8'hFF;
            k++;
            feed = 1'b0;
         end else begin
            ifc.rand_num = 8'hFF;
         end
         if (inject && n == 2) begin
            ifc.place_req = 1'b1;
            ifc.clear_req = 1'b1;
         end else begin
            ifc.place_req = 1'b0;
            ifc.clear_req = 1'b0;
         end
         if (ifc.rand_en) begin
            n_en++;
            feed = 1'b1;
         end
         if (ifc.done || ifc.fail) begin
            lat = n;
            res = ifc.done ? 1 : 2;
            break;
         end
         @(posedge clk); #1;
      end
      ifc.place_req = 1'b0;
      ifc.clear_req = 1'b0;
      ifc.rand_num = 8'hFF;
   endtask

   task automatic do_req(string nm, int mode);
      int n_en, lat, res, exp_en, exp_res, pick;
      pick = -1;
      exp_res = 2;
      exp_en = 0;
      if (mode != 0) begin
         exp_res = 1;
      end else if (m_cnt < 40) begin
         exp_en = 8;
         for (int t = 0; t < 8; t++) begin
            if (m_legal(cands[t])) begin
               pick = int'(cands[t]);
               exp_res = 1;
               exp_en = t + 1;
               break;
            end
         end
      end
      issue(mode, n_en, lat, res);
      chk({nm, "_result"}, 200'(res), 200'(exp_res));
      chk({nm, "_rand_en"}, 200'(n_en), 200'(exp_en));
      if (res == 1 && mode != 0) begin
         m_map = '0;
         m_cnt = 0;
      end else if (res == 1 && pick >= 0) begin
         m_map[pick] = 1'b1;
         m_cnt++;
      end
      last_lat = lat;
      last_en = n_en;
      last_res = res;
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   task automatic fill_cands(logic [7:0] v);
      for (int t = 0; t < 8; t++) cands[t] = v;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("done_fail_excl",
             200'(ifc.done & ifc.fail), 200'd0);
         if (!ifc.busy) begin
            chk("bitmap", ifc.wall_locations, m_map);
            chk("count", 200'(ifc.wall_count), 200'(m_cnt));
         end
      end
   end

   initial begin
      inject = 1'b0;
      ifc.place_req = 1'b0;
      ifc.clear_req = 1'b0;
      ifc.rand_num = 8'hFF;
      len = 0; hx = 14; hy = 11;
      xmn = 0; xmx = 15; ymn = 0; ymx = 12;
      for (int i = 0; i < ML; i++) begin
         sx[i] = 0;
         sy[i] = 0;
      end
      drive_cfg();
      m_map = '0;
      m_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_map", ifc.wall_locations, 200'd0);
      chk("rst_count", 200'(ifc.wall_count), 200'd0);
      chk("rst_ctrl", 200'({ifc.rand_en, ifc.busy,
                            ifc.done, ifc.fail}), 200'd0);
      rst = 1'b0;

      fill_cands(8'hFF);
      cands[0] = 8'h35;
      do_req("t1", 0);
      chk("t1_latency", 200'(last_lat), 200'd4);
      settle();
      chk("t1_bit53", 200'(ifc.wall_locations[53]), 200'd1);
      chk("t1_count", 200'(ifc.wall_count), 200'd1);

      cands[0] = 8'hF0;
      cands[1] = 8'h22;
      do_req("t2", 0);
      chk("t2_rand_en", 200'(last_en), 200'd2);
      settle();
      chk("t2_bit34", 200'(ifc.wall_locations[34]), 200'd1);

      do_req("t3_clear", 1);
      len = 3;
      sx[0] = 7; sy[0] = 7;
      sx[1] = 8; sy[1] = 7;
      sx[2] = 2; sy[2] = 2;
      drive_cfg();
      fill_cands(8'hFF);
      cands[0] = 8'h22;
      cands[1] = 8'h44;
      do_req("t3", 0);
      chk("t3_rand_en", 200'(last_en), 200'd2);
      chk("t3_latency", 200'(last_lat), 200'd14);
      settle();
      chk("t3_bit68", 200'(ifc.wall_locations[68]), 200'd1);
      chk("t3_bit34", 200'(ifc.wall_locations[34]), 200'd0);

      len = 0;
      drive_cfg();
      fill_cands(8'h00);
      do_req("t4", 0);
      chk("t4_fail", 200'(last_res), 200'd2);
      chk("t4_rand_en", 200'(last_en), 200'd8);

      len = 30;
      for (int i = 0; i < ML; i++) begin
         sx[i] = 1;
         sy[i] = 1;
      end
      drive_cfg();
      @(negedge clk);
      for (int w = 0; w < 600 && ifc.busy; w++) @(negedge clk);
      ifc.place_req = 1'b1;
      @(posedge clk); #1;
      ifc.place_req = 1'b0;
      ifc.rand_num = 8'h55;
      repeat (4) settle();
      chk("t6_busy_in_scan", 200'(ifc.busy), 200'd1);
      rst = 1'b1;
      m_map = '0;
      m_cnt = 0;
      settle();
      chk("t6_map", ifc.wall_locations, 200'd0);
      chk("t6_ctrl", 200'({ifc.rand_en, ifc.busy, ifc.done,
                           ifc.fail, ifc.wall_count}), 200'd0);
      rst = 1'b0;
      ifc.rand_num = 8'hFF;
      len = 0;
      drive_cfg();
      fill_cands(8'hFF);
      cands[0] = 8'h66;
      do_req("t6_after", 0);
      chk("t6_after_done", 200'(last_res), 200'd1);

      for (int y = 1; y < 12 && m_cnt < 40; y++) begin
         for (int x = 1; x < 14 && m_cnt < 40; x++) begin
            if (!m_map[y*16+x]) begin
               cands[0] = 8'(y*16 + x);
               do_req("t5_fill", 0);
            end
         end
      end
      cands[0] = 8'hA5;
      do_req("t5_full", 0);
      chk("t5_full_lat", 200'(last_lat), 200'd1);
      chk("t5_full_en", 200'(last_en), 200'd0);
      do_req("t5_clear", 1);
      settle();
      chk("t5_clr_map", ifc.wall_locations, 200'd0);
      chk("t5_clr_count", 200'(ifc.wall_count), 200'd0);

      for (int r = 0; r < 120; r++) begin
         int mode;
         xmn = $urandom_range(0, 2);
         xmx = $urandom_range(13, 15);
         ymn = $urandom_range(0, 2);
         ymx = $urandom_range(10, 12);
         hx = $urandom_range(0, 15);
         hy = $urandom_range(0, 12);
         len = $urandom_range(0, 30);
         for (int i = 0; i < ML; i++) begin
            sx[i] = $urandom_range(2, 9);
            sy[i] = $urandom_range(2, 7);
         end
         drive_cfg();
         for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 7) == 0)
               cands[t] = 8'($urandom_range(200, 255));
            else
               cands[t] = 8'($urandom_range(0, 199));
         end
         mode = $urandom_range(0, 15);
         mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
         inject = ($urandom_range(0, 3) == 0);
         do_req("rnd", mode);
         inject = 1'b0;
      end
      settle();
      settle();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
